mips_pipe_core: RTL and testbench
=================================

# mips_pipe_core

Parametrised five-stage in-order MIPS-subset pipeline: IF, ID, EX, MEM, WB. It is the next-generation CPU core, succeeding the fixed 32-bit core, and adds:
- configurable datapath width, memory depths and register count;
- an asynchronous reset;
- a run/freeze control and memory load ports;
- a HALT instruction with retired-instruction counter;
- a debug register read port;
- hazard-safe branch resolution.

It is the top-level compute block of the design.

## Interface
- XLEN, 32: datapath and register width, 16..32.
- IMEM_WORDS, 1024: instruction memory depth in 32-bit words, power of 2.
- DMEM_WORDS, 1024: data memory depth in XLEN words, power of 2.
- NREGS, 32: register count, power of 2, 2..32. Register indices are taken modulo NREGS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- run  in  1  1 = pipeline advances; 0 = all pipeline state frozen.
- imem_we  in  1  write imem_wdata to IMEM[imem_addr] at the clock edge.
- imem_addr  in  clog2(IMEM_WORDS)  instruction load address.
- imem_wdata  in  32  instruction load data.
- dmem_we  in  1  load-port write to DMEM; has priority over a same-cycle SW.
- dmem_addr  in  clog2(DMEM_WORDS)  data load address.
- dmem_wdata  in  XLEN  data load data.
- dbg_addr  in  5  register index for debug read.
- dbg_data  out  XLEN  combinational read of Regs[dbg_addr mod NREGS].
- pc  out  32  current fetch PC.
- halted  out  1  HALT has retired.
- retired  out  32  count of retired instructions.

## Operation
Supported instructions, standard MIPS encoding:
- R-type (opcode 0): add 32, sub 34, and 36, or 37, slt 42 (signed compare).
- lw 35, sw 43, beq 4, bne 5.
- HALT, opcode 63.
- Any other opcode or funct executes as a nop.

Arithmetic and addressing:
- Immediates are sign-extended to XLEN.
- Arithmetic wraps modulo 2^XLEN.
- DMEM index = (ALU result >> 2) mod DMEM_WORDS.
- IMEM index = PC[..2] mod IMEM_WORDS.

Register file:
- r0 reads 0, ignores writes and is never a forwarding source.
- WB writes are write-first: ID sees a register written in the same cycle.

Validity:
- Each stage carries a valid bit. Stall and flush inject bubbles with valid=0.
- A fetched all-zero word is a valid instruction.

Forwarding to EX operands rs and rt (including SW store data):
- EX/MEM ALU result has priority.
- Otherwise the MEM/WB value (ALU or load).
- Otherwise the ID/EX register copy.

Load-use stall:
- Condition: ID holds an R-type, lw or sw, and ID/EX holds a valid lw whose rt (nonzero) equals ID's rs or rt.
- Action: PC and IF/ID hold; a bubble goes to EX. Costs 1 cycle.

Branches are resolved in ID:
- ID stalls while a valid ID/EX or EX/MEM instruction writes the branch's rs or rt (nonzero).
- Once clear, ID compares register-file values.
- Taken: PC = branch PC + 4 + (sext(imm) << 2), and the IF/ID instruction is squashed (1 bubble).

HALT:
- When HALT is in ID, fetch stops: PC holds and bubbles are fed.
- When HALT reaches WB, halted = 1, retired is incremented, and all state freezes until reset.

Counting:
- retired increments once per valid instruction in WB and saturates at 2^32-1.

run = 0:
- No PC, pipeline, register, counter or SW update.
- Load ports remain active.

## Timing
Reset values (asynchronous, immediate, no clock required):
- pc = 0, halted = 0, retired = 0.
- All stage valid bits = 0, all registers = 0.
- Memories are not cleared.

Latency:
- Instruction at PC 0 with run = 1 from reset release: fetched at edge 1, its register write and retired increment occur at edge 5.
- Steady state: 1 instruction per cycle.
- Load-use: +1 cycle.
- Branch dependent on an ID/EX producer: +2 cycles; on an EX/MEM producer: +1 cycle.
- Taken branch: +1 bubble.

Simultaneous events:
- Stall and taken branch in the same cycle: the stall wins and the branch re-evaluates next cycle.
- Reset asserted mid-run: aborts all in-flight instructions.

## Test plan
- Load/ALU with load-use: DMEM[0]=5, DMEM[1]=7; program lw r1,0(r0); lw r2,4(r0); add r3,r1,r2; HALT -> r3=12, halted rises at edge 9, retired=4.
- Back-to-back forwarding: r1=5, r2=7; add r3,r1,r2; sub r4,r3,r1; or r5,r4,r3 -> r4=7, r5=15, no stall cycles.
- Branches: beq r1,r1,+1 skips the next add (its rd stays 0), 1 bubble; bne r1,r1 not taken -> sequential execution. Branch immediately after a producing add -> stalls 2 cycles, correct target.
- Memory and signed ops: sw r3,8(r0) then lw r6,8(r0) -> r6=12. slt with r7=-1, r1=5 -> 1. 0x7FFFFFFF+1 -> 0x80000000. Repeat the suite at XLEN=16 (0x7FFF+1 -> 0x8000).
- Freeze: run=0 for 10 cycles mid-program -> pc, retired and registers unchanged, a load-port DMEM write lands, results identical after resuming.
- Async reset: assert reset between edges mid-program -> pc=0, halted=0, retired=0 with no clock; the rerun completes identically.

Source files
------------

// File: rtl/mips_pipe_core.sv
// Five-stage in-order MIPS-subset pipeline (IF/ID/EX/MEM/WB) with configurable widths,
// run/freeze control, memory load ports, HALT, retired counter and a debug register port.
module mips_pipe_core #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned NREGS      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          dmem_we,
  input  logic [$clog2(DMEM_WORDS)-1:0] dmem_addr,
  input  logic [XLEN-1:0]               dmem_wdata,
  input  logic [4:0]                    dbg_addr,
  output logic [XLEN-1:0]               dbg_data,
  output logic [31:0]                   pc,
  output logic                          halted,
  output logic [31:0]                   retired
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);
  localparam int unsigned RAW = $clog2(NREGS);

  typedef logic [RAW-1:0]  ridx_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'd0,
    OP_BEQ   = 6'd4,
    OP_BNE   = 6'd5,
    OP_LW    = 6'd35,
    OP_SW    = 6'd43,
    OP_HALT  = 6'd63
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'd32,
    FN_SUB = 6'd34,
    FN_AND = 6'd36,
    FN_OR  = 6'd37,
    FN_SLT = 6'd42
  } funct_e;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  logic [31:0] imem_q [IMEM_WORDS];
  word_t       dmem_q [DMEM_WORDS];
  word_t       regs_q [NREGS];

  logic [31:0] pc_q, pc_d, retired_q;
  logic        halted_q;

  logic        ifid_valid_q;
  logic [31:0] ifid_instr_q, ifid_pc_q;

  logic        idex_valid_q, idex_wr_q, idex_lw_q, idex_sw_q, idex_halt_q;
  alu_op_e     idex_alu_q;
  ridx_t       idex_dst_q, idex_rs_q, idex_rt_q;
  word_t       idex_a_q, idex_b_q, idex_imm_q;

  logic        exmem_valid_q, exmem_wr_q, exmem_lw_q, exmem_sw_q, exmem_halt_q;
  ridx_t       exmem_dst_q;
  word_t       exmem_alu_q, exmem_st_q;

  logic        memwb_valid_q, memwb_wr_q, memwb_halt_q;
  ridx_t       memwb_dst_q;
  word_t       memwb_val_q;

  logic        adv;
  assign adv = run & ~halted_q;

  // ---------------- ID: decode, register read, hazards, branch resolution
  logic [5:0]  id_op, id_funct;
  logic [15:0] id_imm;
  ridx_t       id_rs, id_rt, id_rd, id_dst;
  logic        id_is_r, id_is_lw, id_is_sw, id_is_beq, id_is_bne, id_is_halt, id_wr;
  alu_op_e     id_alu;
  word_t       id_a, id_b, id_immx;
  logic        wb_we, load_use, br_hz, stall, taken, halt_pend;
  logic [31:0] br_tgt;

  assign id_op    = ifid_instr_q[31:26];
  assign id_rs    = ifid_instr_q[21 +: RAW];
  assign id_rt    = ifid_instr_q[16 +: RAW];
  assign id_rd    = ifid_instr_q[11 +: RAW];
  assign id_funct = ifid_instr_q[5:0];
  assign id_imm   = ifid_instr_q[15:0];

  assign wb_we = memwb_valid_q & memwb_wr_q & (memwb_dst_q != '0);

  always_comb begin
    id_is_r    = (id_op == OP_RTYPE);
    id_is_lw   = (id_op == OP_LW);
    id_is_sw   = (id_op == OP_SW);
    id_is_beq  = (id_op == OP_BEQ);
    id_is_bne  = (id_op == OP_BNE);
    id_is_halt = (id_op == OP_HALT);

    id_alu = ALU_NOP;
    if (id_is_r) begin
      case (id_funct)
        FN_ADD:  id_alu = ALU_ADD;
        FN_SUB:  id_alu = ALU_SUB;
        FN_AND:  id_alu = ALU_AND;
        FN_OR:   id_alu = ALU_OR;
        FN_SLT:  id_alu = ALU_SLT;
        default: id_alu = ALU_NOP;
      endcase
    end else if (id_is_lw || id_is_sw) begin
      id_alu = ALU_ADD;
    end
    id_wr  = (id_is_r && id_alu != ALU_NOP) || id_is_lw;
    id_dst = id_is_lw ? id_rt : id_rd;

    id_immx        = {XLEN{id_imm[15]}};
    id_immx[15:0]  = id_imm;

    // Write-first register file: a WB write this cycle is visible to ID.
    id_a = regs_q[id_rs];
    if (wb_we && memwb_dst_q == id_rs) id_a = memwb_val_q;
    if (id_rs == '0) id_a = '0;
    id_b = regs_q[id_rt];
    if (wb_we && memwb_dst_q == id_rt) id_b = memwb_val_q;
    if (id_rt == '0) id_b = '0;

    load_use = ifid_valid_q && (id_is_r || id_is_lw || id_is_sw) &&
               idex_valid_q && idex_lw_q && (idex_dst_q != '0) &&
               (idex_dst_q == id_rs || idex_dst_q == id_rt);
    br_hz    = ifid_valid_q && (id_is_beq || id_is_bne) &&
               ((idex_valid_q && idex_wr_q && (idex_dst_q != '0) &&
                 (idex_dst_q == id_rs || idex_dst_q == id_rt)) ||
                (exmem_valid_q && exmem_wr_q && (exmem_dst_q != '0) &&
                 (exmem_dst_q == id_rs || exmem_dst_q == id_rt)));
    stall    = load_use || br_hz;
    taken    = ifid_valid_q && !stall &&
               ((id_is_beq && id_a == id_b) || (id_is_bne && id_a != id_b));
    br_tgt   = ifid_pc_q + 32'd4 + {{14{id_imm[15]}}, id_imm, 2'b00};

    // Any HALT in flight keeps fetch parked so nothing younger enters.
    halt_pend = (ifid_valid_q && id_is_halt) || (idex_valid_q && idex_halt_q) ||
                (exmem_valid_q && exmem_halt_q) || (memwb_valid_q && memwb_halt_q);

    if (stall)          pc_d = pc_q;
    else if (taken)     pc_d = br_tgt;
    else if (halt_pend) pc_d = pc_q;
    else                pc_d = pc_q + 32'd4;
  end

  // ---------------- EX: forwarding and ALU
  word_t ex_a, ex_b, ex_opb, ex_res;

  always_comb begin
    ex_a = idex_a_q;
    if (exmem_valid_q && exmem_wr_q && !exmem_lw_q && exmem_dst_q != '0 && exmem_dst_q == idex_rs_q)
      ex_a = exmem_alu_q;
    else if (wb_we && memwb_dst_q == idex_rs_q)
      ex_a = memwb_val_q;
    ex_b = idex_b_q;
    if (exmem_valid_q && exmem_wr_q && !exmem_lw_q && exmem_dst_q != '0 && exmem_dst_q == idex_rt_q)
      ex_b = exmem_alu_q;
    else if (wb_we && memwb_dst_q == idex_rt_q)
      ex_b = memwb_val_q;

    ex_opb = (idex_lw_q || idex_sw_q) ? idex_imm_q : ex_b;
    case (idex_alu_q)
      ALU_ADD: ex_res = ex_a + ex_opb;
      ALU_SUB: ex_res = ex_a - ex_opb;
      ALU_AND: ex_res = ex_a & ex_opb;
      ALU_OR:  ex_res = ex_a | ex_opb;
      ALU_SLT: ex_res = ($signed(ex_a) < $signed(ex_opb)) ? word_t'(1) : '0;
      default: ex_res = '0;
    endcase
  end

  // ---------------- MEM
  logic [DAW-1:0] dm_idx;
  word_t          mem_val;

  assign dm_idx  = exmem_alu_q[DAW+1:2];
  assign mem_val = exmem_lw_q ? dmem_q[dm_idx] : exmem_alu_q;

  // ---------------- control state (async reset)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= '0;
      halted_q      <= 1'b0;
      retired_q     <= '0;
      ifid_valid_q  <= 1'b0;
      idex_valid_q  <= 1'b0;
      exmem_valid_q <= 1'b0;
      memwb_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (adv) begin
      pc_q <= pc_d;
      if (!stall) ifid_valid_q <= !(taken || halt_pend);
      idex_valid_q  <= ifid_valid_q && !stall;
      exmem_valid_q <= idex_valid_q;
      memwb_valid_q <= exmem_valid_q;
      if (wb_we) regs_q[memwb_dst_q] <= memwb_val_q;
      if (memwb_valid_q) begin
        if (retired_q != '1) retired_q <= retired_q + 32'd1;
        if (memwb_halt_q)    halted_q  <= 1'b1;
      end
    end
  end

  // ---------------- pipeline payload (qualified by the valid bits above)
  always_ff @(posedge clock) begin
    if (adv) begin
      if (!stall) begin
        ifid_instr_q <= imem_q[pc_q[IAW+1:2]];
        ifid_pc_q    <= pc_q;
      end
      idex_wr_q   <= id_wr;
      idex_lw_q   <= id_is_lw;
      idex_sw_q   <= id_is_sw;
      idex_halt_q <= id_is_halt;
      idex_alu_q  <= id_alu;
      idex_dst_q  <= id_dst;
      idex_rs_q   <= id_rs;
      idex_rt_q   <= id_rt;
      idex_a_q    <= id_a;
      idex_b_q    <= id_b;
      idex_imm_q  <= id_immx;

      exmem_wr_q   <= idex_wr_q;
      exmem_lw_q   <= idex_lw_q;
      exmem_sw_q   <= idex_sw_q;
      exmem_halt_q <= idex_halt_q;
      exmem_dst_q  <= idex_dst_q;
      exmem_alu_q  <= ex_res;
      exmem_st_q   <= ex_b;

      memwb_wr_q   <= exmem_wr_q;
      memwb_halt_q <= exmem_halt_q;
      memwb_dst_q  <= exmem_dst_q;
      memwb_val_q  <= mem_val;
    end
  end

  // Load port is written last so it wins an address clash with a store.
  always_ff @(posedge clock) begin
    if (imem_we) imem_q[imem_addr] <= imem_wdata;
    if (adv && exmem_valid_q && exmem_sw_q) dmem_q[dm_idx] <= exmem_st_q;
    if (dmem_we) dmem_q[dmem_addr] <= dmem_wdata;
  end

  logic unused_bits;
  assign unused_bits = ^{ifid_instr_q, dbg_addr};

  assign dbg_data = regs_q[dbg_addr[RAW-1:0]];
  assign pc       = pc_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_mips_pipe_core.sv
// Directed bench for mips_pipe_core: runs each program on a 32-bit and a 16-bit
// instance in lockstep and checks hand-computed timing and register results.
module tb_mips_pipe_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic        dmem_we = 1'b0;
  logic [9:0]  dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [15:0] dmem_wdata16 = '0;
  logic [4:0]  dbg_addr = '0;

  logic [31:0] dbg_data, pc, retired;
  logic        halted;
  logic [15:0] dbg_data16;
  logic [31:0] pc16, retired16;
  logic        halted16;

  mips_pipe_core u_dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .pc(pc), .halted(halted), .retired(retired)
  );

  mips_pipe_core #(.XLEN(16), .IMEM_WORDS(64), .DMEM_WORDS(64), .NREGS(16)) u_dut16 (
    .clock(clock), .reset(reset), .run(run),
    .imem_we(imem_we), .imem_addr(imem_addr[5:0]), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr[5:0]), .dmem_wdata(dmem_wdata16),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data16),
    .pc(pc16), .halted(halted16), .retired(retired16)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] prog [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  task automatic dmem_put(input int unsigned a, input logic [31:0] v32, input logic [15:0] v16);
    dmem_we = 1'b1; dmem_addr = a[9:0]; dmem_wdata = v32; dmem_wdata16 = v16;
    step(1);
    dmem_we = 1'b0;
  endtask

  // Holds reset, loads prog and the data image, then releases with run=1 so the
  // next rising edge is edge 1.
  task automatic load_and_start();
    reset = 1'b1; run = 1'b0;
    foreach (prog[i]) begin
      imem_we = 1'b1; imem_addr = i[9:0]; imem_wdata = prog[i];
      step(1);
    end
    imem_we = 1'b0;
    dmem_put(0,  32'd5,         16'd5);
    dmem_put(1,  32'd7,         16'd7);
    dmem_put(2,  32'hFFFF_FFFF, 16'hFFFF);
    dmem_put(3,  32'h7FFF_FFFF, 16'h7FFF);
    dmem_put(4,  32'd1,         16'd1);
    dmem_put(10, 32'd0,         16'd0);
    reset = 1'b0; run = 1'b1;
  endtask

  task automatic reg_chk(input string tag, input logic [4:0] r, input logic [31:0] w32,
                         input logic [15:0] w16);
    dbg_addr = r;
    #1;
    check(tag, dbg_data, w32);
    check({tag, ".x16"}, {16'd0, dbg_data16}, {16'd0, w16});
  endtask

  task automatic stat_chk(input string tag, input logic [31:0] wpc, input logic [31:0] wret,
                          input logic whalt);
    check({tag, ".pc"}, pc, wpc);
    check({tag, ".retired"}, retired, wret);
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, whalt});
    check({tag, ".pc.x16"}, pc16, wpc);
    check({tag, ".retired.x16"}, retired16, wret);
    check({tag, ".halted.x16"}, {31'd0, halted16}, {31'd0, whalt});
  endtask

  task automatic halt_at(input string tag, input int unsigned edge_n);
    step(edge_n - 1);
    check({tag, ".pre_halt"}, {31'd0, halted}, 32'd0);
    check({tag, ".pre_halt.x16"}, {31'd0, halted16}, 32'd0);
    step(1);
  endtask

  task automatic build_mem_prog();
    prog.delete();
    prog.push_back(i_op(6'd35, 5'd1,  5'd0, 16'd0));
    prog.push_back(i_op(6'd35, 5'd2,  5'd0, 16'd4));
    prog.push_back(i_op(6'd35, 5'd7,  5'd0, 16'd8));
    prog.push_back(i_op(6'd35, 5'd11, 5'd0, 16'd12));
    prog.push_back(i_op(6'd35, 5'd12, 5'd0, 16'd16));
    prog.push_back(r_op(6'd32, 5'd3, 5'd1, 5'd2));
    prog.push_back(i_op(6'd43, 5'd3,  5'd0, 16'd8));
    prog.push_back(i_op(6'd35, 5'd6,  5'd0, 16'd8));
    prog.push_back(r_op(6'd42, 5'd8, 5'd7, 5'd1));
    prog.push_back(r_op(6'd42, 5'd9, 5'd1, 5'd7));
    prog.push_back(r_op(6'd32, 5'd13, 5'd11, 5'd12));
    prog.push_back(i_op(6'd35, 5'd14, 5'd0, 16'd40));
    prog.push_back(HALT);
  endtask

  task automatic mem_results(input string tag, input logic [31:0] r14);
    reg_chk({tag, ".r3"},  5'd3,  32'd12, 16'd12);
    reg_chk({tag, ".r6"},  5'd6,  32'd12, 16'd12);
    reg_chk({tag, ".r7"},  5'd7,  32'hFFFF_FFFF, 16'hFFFF);
    reg_chk({tag, ".slt_neg"}, 5'd8, 32'd1, 16'd1);
    reg_chk({tag, ".slt_pos"}, 5'd9, 32'd0, 16'd0);
    reg_chk({tag, ".ovf"}, 5'd13, 32'h8000_0000, 16'h8000);
    reg_chk({tag, ".r14"}, 5'd14, r14, r14[15:0]);
  endtask

  initial begin
    #1;
    stat_chk("reset", 32'd0, 32'd0, 1'b0);

    // Load-use: lw r1; lw r2; add r3,r1,r2; HALT
    prog.delete();
    prog.push_back(i_op(6'd35, 5'd1, 5'd0, 16'd0));
    prog.push_back(i_op(6'd35, 5'd2, 5'd0, 16'd4));
    prog.push_back(r_op(6'd32, 5'd3, 5'd1, 5'd2));
    prog.push_back(HALT);
    load_and_start();
    step(4);
    check("lat.retired_e4", retired, 32'd0);
    step(1);
    check("lat.retired_e5", retired, 32'd1);
    reg_chk("lat.r1_e5", 5'd1, 32'd5, 16'd5);
    step(3);
    check("lu.pre_halt", {31'd0, halted}, 32'd0);
    step(1);
    stat_chk("lu.halt", 32'd16, 32'd4, 1'b1);
    reg_chk("lu.r3", 5'd3, 32'd12, 16'd12);
    step(3);
    stat_chk("lu.frozen", 32'd16, 32'd4, 1'b1);

    // Back-to-back forwarding, no stalls: HALT (7th) retires at edge 11
    prog.delete();
    prog.push_back(i_op(6'd35, 5'd1, 5'd0, 16'd0));
    prog.push_back(i_op(6'd35, 5'd2, 5'd0, 16'd4));
    prog.push_back(NOP);
    prog.push_back(r_op(6'd32, 5'd3, 5'd1, 5'd2));
    prog.push_back(r_op(6'd34, 5'd4, 5'd3, 5'd1));
    prog.push_back(r_op(6'd37, 5'd5, 5'd4, 5'd3));
    prog.push_back(HALT);
    load_and_start();
    halt_at("fwd", 11);
    stat_chk("fwd.halt", 32'd28, 32'd7, 1'b1);
    reg_chk("fwd.r4", 5'd4, 32'd7, 16'd7);
    reg_chk("fwd.r5", 5'd5, 32'd15, 16'd15);

    // Branches: taken beq (1 bubble), untaken bne, beq after producer (2 stalls)
    prog.delete();
    prog.push_back(i_op(6'd35, 5'd1, 5'd0, 16'd0));
    prog.push_back(NOP);
    prog.push_back(NOP);
    prog.push_back(i_op(6'd4, 5'd1, 5'd1, 16'd1));
    prog.push_back(r_op(6'd32, 5'd6, 5'd1, 5'd1));
    prog.push_back(i_op(6'd5, 5'd1, 5'd1, 16'd1));
    prog.push_back(r_op(6'd32, 5'd7, 5'd1, 5'd1));
    prog.push_back(r_op(6'd32, 5'd8, 5'd1, 5'd1));
    prog.push_back(r_op(6'd32, 5'd9, 5'd1, 5'd1));
    prog.push_back(i_op(6'd4, 5'd7, 5'd9, 16'd1));
    prog.push_back(r_op(6'd32, 5'd10, 5'd1, 5'd1));
    prog.push_back(HALT);
    load_and_start();
    halt_at("br", 18);
    stat_chk("br.halt", 32'd48, 32'd10, 1'b1);
    reg_chk("br.skip1", 5'd6, 32'd0, 16'd0);
    reg_chk("br.notaken", 5'd7, 32'd10, 16'd10);
    reg_chk("br.r9", 5'd9, 32'd10, 16'd10);
    reg_chk("br.skip2", 5'd10, 32'd0, 16'd0);

    // Memory, signed compare and overflow: 13 instructions, no stalls
    build_mem_prog();
    load_and_start();
    halt_at("mem", 17);
    stat_chk("mem.halt", 32'd52, 32'd13, 1'b1);
    mem_results("mem", 32'd0);

    // Freeze 10 cycles after edge 6 with a load-port write to DMEM[10]
    build_mem_prog();
    load_and_start();
    step(6);
    stat_chk("frz.before", 32'd24, 32'd2, 1'b0);
    run = 1'b0;
    dmem_put(10, 32'h0000_0055, 16'h0055);
    step(9);
    stat_chk("frz.held", 32'd24, 32'd2, 1'b0);
    reg_chk("frz.r2", 5'd2, 32'd7, 16'd7);
    reg_chk("frz.r3", 5'd3, 32'd0, 16'd0);
    run = 1'b1;
    halt_at("frz", 11);
    stat_chk("frz.halt", 32'd52, 32'd13, 1'b1);
    mem_results("frz", 32'h0000_0055);

    // Asynchronous reset between edges, then a clean rerun
    build_mem_prog();
    load_and_start();
    step(8);
    stat_chk("ar.mid", 32'd32, 32'd4, 1'b0);
    #2 reset = 1'b1;
    #1;
    stat_chk("ar.async", 32'd0, 32'd0, 1'b0);
    reg_chk("ar.r1", 5'd1, 32'd0, 16'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    halt_at("ar", 17);
    stat_chk("ar.halt", 32'd52, 32'd13, 1'b1);
    mem_results("ar", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
